// File: rtl/arb_pkg.sv
// Shared types and sizes for the eight-way round-robin arbiter.
package arb_pkg;
  localparam int unsigned ARB_N    = 8;
  localparam int unsigned ARB_IDXW = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational masked priority picker: first set request at or above ptr, wrapping 7->0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]    req,
  input  logic [ARB_IDXW-1:0] ptr,
  output logic                valid,
  output logic [ARB_IDXW-1:0] idx,
  output logic [ARB_N-1:0]    onehot
);
  logic [2*ARB_N-1:0]  w_dbl;
  logic [ARB_N-1:0]    w_rot;
  logic [ARB_IDXW-1:0] w_off;
  logic                w_found;

  // Bit k of w_rot is req[(ptr+k) mod 8], so the lowest set bit is the winner.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[ARB_N-1:0];

  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < ARB_N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_off   = ARB_IDXW'(k);
        w_found = 1'b1;
      end
    end
  end

  assign valid  = |req;
  assign idx    = ptr + w_off;
  assign onehot = valid ? (ARB_N'(1) << idx) : '0;
endmodule

// File: rtl/arbiter_rr8.sv
// Eight-requester round-robin arbiter with hold-until-release grants.
// Optional forced revocation after MAX_HOLD cycles when ARB_RR8_TIMEOUT_EN is defined.
module arbiter_rr8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ARB_N-1:0]    req,
  input  logic [ARB_N-1:0]    done,
  output logic [ARB_N-1:0]    grant,
  output logic [ARB_IDXW-1:0] grant_idx,
  output logic                busy,
  output logic                any_req,
  output logic                timeout
);
  arb_state_t          r_state;
  logic [ARB_N-1:0]    r_grant;
  logic [ARB_IDXW-1:0] r_idx;
  logic [ARB_IDXW-1:0] r_ptr;
  logic                r_busy;

  logic                w_valid;
  logic [ARB_IDXW-1:0] w_pidx;
  logic [ARB_N-1:0]    w_onehot;
  logic                w_vol_rel;
  logic                w_force;
  logic                w_release;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arbiter_rr8: MAX_HOLD out of range 2..255");
  end

  // In OWNED, r_ptr already points past the owner, so the owner is picked last.
  rr_pick8 u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .valid  (w_valid),
    .idx    (w_pidx),
    .onehot (w_onehot)
  );

  assign w_vol_rel = done[r_idx] || !req[r_idx];
  assign w_release = w_vol_rel || w_force;

`ifdef ARB_RR8_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold;
  logic       r_timeout;

  assign w_force = (r_state == ST_OWNED) && (r_hold == HOLD_LAST) && !w_vol_rel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (r_state == ST_OWNED && !w_release) r_hold <= r_hold + 8'd1;
      else                                   r_hold <= '0;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant <= w_onehot;
            r_idx   <= w_pidx;
            r_ptr   <= w_pidx + 3'd1;
            r_busy  <= 1'b1;
            r_state <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (w_release) begin
            if (w_valid) begin
              r_grant <= w_onehot;
              r_idx   <= w_pidx;
              r_ptr   <= w_pidx + 3'd1;
            end else begin
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_idx;
  assign busy      = r_busy;
  assign any_req   = w_valid;
endmodule

// File: tb/tb_arbiter_rr8.sv
// Directed table-driven bench for arbiter_rr8, plus hold/timeout sequences.
module tb_arbiter_rr8;
  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       any_req;
  logic       timeout;

  int unsigned n_cmp;
  int unsigned n_err;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tv[$];

  arbiter_rr8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .any_req   (any_req),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] dn,
                     input logic [7:0] g, input logic [2:0] ix, input logic b);
    vec_t v;
    v.rst_n = r; v.req = rq; v.done = dn;
    v.grant = g; v.idx = ix; v.busy = b; v.to = 1'b0;
    tv.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = '0;
    done  = '0;

    // reset with all requests held, then first grant
    add(0, 8'hFF, 8'h00, 8'h00, 3'd0, 0);
    add(0, 8'hFF, 8'h00, 8'h00, 3'd0, 0);
    add(1, 8'hFF, 8'h00, 8'h01, 3'd0, 1);
    // rotation with owner done each cycle, wrap 7->0
    add(1, 8'hFF, 8'h01, 8'h02, 3'd1, 1);
    add(1, 8'hFF, 8'h02, 8'h04, 3'd2, 1);
    add(1, 8'hFF, 8'h04, 8'h08, 3'd3, 1);
    add(1, 8'hFF, 8'h08, 8'h10, 3'd4, 1);
    add(1, 8'hFF, 8'h10, 8'h20, 3'd5, 1);
    add(1, 8'hFF, 8'h20, 8'h40, 3'd6, 1);
    add(1, 8'hFF, 8'h40, 8'h80, 3'd7, 1);
    add(1, 8'hFF, 8'h80, 8'h01, 3'd0, 1);
    // owner 3 ignores done[5]
    add(1, 8'h28, 8'h01, 8'h08, 3'd3, 1);
    add(1, 8'h28, 8'h20, 8'h08, 3'd3, 1);
    add(1, 8'h28, 8'h20, 8'h08, 3'd3, 1);
    add(1, 8'h28, 8'h08, 8'h20, 3'd5, 1);
    // sole requester 2 re-granted, ptr then 3
    add(1, 8'h04, 8'h00, 8'h04, 3'd2, 1);
    add(1, 8'h04, 8'h04, 8'h04, 3'd2, 1);
    add(1, 8'h0C, 8'h04, 8'h08, 3'd3, 1);
    // release to idle, idx holds
    add(1, 8'h00, 8'h00, 8'h00, 3'd3, 0);
    add(1, 8'h00, 8'h00, 8'h00, 3'd3, 0);
    // ptr=4 from idle wraps to 0; new request joins release-cycle pick
    add(1, 8'h01, 8'h00, 8'h01, 3'd0, 1);
    add(1, 8'h81, 8'h01, 8'h80, 3'd7, 1);
    add(1, 8'h81, 8'h00, 8'h80, 3'd7, 1);
    add(1, 8'h01, 8'h00, 8'h01, 3'd0, 1);
    // reset mid-grant of 4 returns ptr to 0
    add(1, 8'h10, 8'h01, 8'h10, 3'd4, 1);
    add(0, 8'h30, 8'h00, 8'h00, 3'd0, 0);
    add(1, 8'h30, 8'h00, 8'h10, 3'd4, 1);

    for (int i = 0; i < tv.size(); i++) begin
      rst_n = tv[i].rst_n;
      req   = tv[i].req;
      done  = tv[i].done;
      #1;
      chk($sformatf("row%0d any_req", i), 32'(any_req), 32'(tv[i].req != 8'h00));
      tick();
      chk($sformatf("row%0d grant", i), 32'(grant), 32'(tv[i].grant));
      chk($sformatf("row%0d grant_idx", i), 32'(grant_idx), 32'(tv[i].idx));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("row%0d timeout", i), 32'(timeout), 32'(tv[i].to));
    end

    // hold sequence: requester 0 keeps its request while 1 waits
    rst_n = 1'b0; req = '0; done = '0;
    tick(); tick();
    rst_n = 1'b1; req = 8'h03;
    tick();
`ifdef ARB_RR8_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("hold%0d grant", c), 32'(grant), 32'h01);
      chk($sformatf("hold%0d timeout", c), 32'(timeout), 32'h0);
      tick();
    end
    chk("revoke grant", 32'(grant), 32'h02);
    chk("revoke idx", 32'(grant_idx), 32'h1);
    chk("revoke timeout", 32'(timeout), 32'h1);
    tick();
    chk("post grant", 32'(grant), 32'h02);
    chk("post timeout", 32'(timeout), 32'h0);
    tick(); tick();
    done = 8'h02;
    tick();
    done = 8'h00;
    chk("vol grant", 32'(grant), 32'h01);
    chk("vol timeout", 32'(timeout), 32'h0);
`else
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("hold%0d grant", c), 32'(grant), 32'h01);
      chk($sformatf("hold%0d timeout", c), 32'(timeout), 32'h0);
      tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arbiter_rr8.md
# arbiter_rr8

Round-robin arbiter that shares one single-master resource (the Hack memory-mapped I/O bus) among eight requesters. Request detection is an eight-way OR of the request vector. A sequential grant machine holds ownership until the owner releases it, then rotates priority. It sits between the peripheral request lines and the bus mux select.

## Interface
- `MAX_HOLD`, default 16: maximum cycles one grant may be held. Used only when `ARB_RR8_TIMEOUT_EN` is defined. Legal range 2..255.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `req`  in  8  request lines, level-sensitive, one per requester.
- `done`  in  8  release strobe per requester. Only the bit of the current owner is honoured.
- `grant`  out  8  one-hot grant, registered. All-zero when idle.
- `grant_idx`  out  3  binary index of the owner, registered. Holds its last value when idle.
- `busy`  out  1  high while any grant is held. Equals the OR of `grant`.
- `any_req`  out  1  combinational OR of `req[7:0]`.
- `timeout`  out  1  one-cycle pulse when a grant is force-revoked. Tied 0 without the macro.

## Operation
- Reset values: `grant`=0, `grant_idx`=0, `busy`=0, `timeout`=0, rotation pointer `ptr`=0, hold counter=0, state=IDLE.
- Two states: IDLE and OWNED.
- **IDLE**
  - If `any_req` is 1, pick the first set `req` bit searching upward from `ptr`, wrapping 7→0.
  - At the edge: register one-hot `grant`, set `grant_idx`, set `ptr`=idx+1 mod 8, go to OWNED.
  - If no requests, remain in IDLE.
- **OWNED**: a release occurs when `done[grant_idx]`=1 or `req[grant_idx]`=0.
  - On release with other requests pending, the new pick uses the already-advanced `ptr`. The new grant is registered at the same edge (back-to-back, no idle cycle) and `ptr` advances again.
  - On release with nothing pending, go to IDLE and clear `grant` at that edge.
  - The releasing requester may be re-granted immediately only if it is the sole requester. Its `req` bit is sampled in the release cycle.
- `done` bits of non-owners are ignored. They are never latched.
- `grant` is never multi-hot. It changes only at clock edges.
- A `req` rising while it is already the owner has no effect.

## Timing
- Request-to-grant latency in IDLE: 1 cycle. A `req` sampled high at edge N gives `grant` high after edge N.
- Release-to-next-grant latency: 0 idle cycles. The old grant drops and the new grant rises at the same edge.
- Release and a simultaneous new request from a higher-priority line: the new request participates in the pick that same cycle.
- `rst_n` low mid-grant: `grant`, `busy` and `timeout` read 0 after the next edge. `ptr` returns to 0.
- `any_req` is combinational, with zero latency from `req`.

## Configuration
- **`ARB_RR8_TIMEOUT_EN` defined**
  - An 8-bit hold counter clears on every new grant and increments each cycle in OWNED.
  - When the counter equals `MAX_HOLD`-1 and no voluntary release occurs, the grant is force-released at that edge. Arbitration proceeds as a normal release.
  - `timeout` is high for exactly the following cycle. An owner therefore holds for at most `MAX_HOLD` cycles.
  - A voluntary release in the same cycle takes precedence: no `timeout` pulse.
- **`ARB_RR8_TIMEOUT_EN` undefined**: no counter is instantiated, `timeout` is constant 0, and grants are unbounded.

## Structure
- Shared package `arb_pkg` holds:
  - the state encodings `ST_IDLE`=1'b0 and `ST_OWNED`=1'b1;
  - `ARB_N`=8;
  - `ARB_IDXW`=3.
- Sub-module `rr_pick8`: combinational masked priority picker.
  - Inputs: `req[7:0]`, `ptr[2:0]`.
  - Outputs: `valid`, `idx[2:0]`, `onehot[7:0]`.
  - It uses rotate, find-first-set and rotate back.
  - Instantiated once. Its `valid` output provides the OR used for `any_req`.

## Test plan
- Reset with `req`=8'hFF held: after `rst_n` releases, `grant`=8'h01 one cycle later, `grant_idx`=0, `busy`=1.
- `req`=8'hFF constant, pulse `done` of the owner each cycle: grant sequence 01,02,04,…,80,01. Wrap-around is correct and there are no gap cycles.
- Owner 3 holds while `done[5]`=1 and `req[5]`=1: `done[5]` is ignored and `grant` stays 8'h08. On `done[3]`, the next grant is 8'h20.
- Sole requester 2 pulses `done[2]` while keeping `req[2]`=1: it is re-granted at the same edge, `grant` stays 8'h04, and `ptr`=3.
- With `ARB_RR8_TIMEOUT_EN` and `MAX_HOLD`=4, requester 0 holds with `req`=8'h03: `grant` is 8'h01 for 4 cycles, then 8'h02 with a `timeout` pulse of 1 cycle. Without the macro, `grant` stays 8'h01 indefinitely.
- `rst_n` dropped while `grant`=8'h10: after the next edge, `grant`=0, `busy`=0, and the next grant with `req`=8'h30 is 8'h10 (`ptr` reset to 0).
